// File: rtl/rf_pkg.sv
// Shared sizing constants for the register file and its pending-write scoreboard.
package rf_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;
  localparam logic [4:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: busy bit per register, reserved on issue, released on write-back.
// Busy flags are combinational from addresses and the write-back bus; stall blocks new issues.
module reg_scoreboard #(
  parameter int ADDR_W = rf_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              stall,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(rf_pkg::ZERO_REG);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             wb_vld, iss_acc, cnt_inc, cnt_dec;

  assign wb_vld  = wb_en && (wb_addr != ZR);
  assign rs_busy = busy_q[rs_addr] && !(wb_vld && (wb_addr == rs_addr)) && (rs_addr != ZR);
  assign rt_busy = busy_q[rt_addr] && !(wb_vld && (wb_addr == rt_addr)) && (rt_addr != ZR);
  assign stall   = rs_busy || rt_busy;
  assign iss_acc = iss_en && (iss_addr != ZR) && !stall;

  // A same-edge issue to the register being written back keeps it reserved,
  // so that write-back must not decrement the count.
  assign cnt_inc = iss_acc && !busy_q[iss_addr];
  assign cnt_dec = wb_vld && busy_q[wb_addr] && !(iss_acc && (iss_addr == wb_addr));

  always_comb begin
    busy_d = busy_q;
    if (wb_vld)  busy_d[wb_addr]  = 1'b0;
    if (iss_acc) busy_d[iss_addr] = 1'b1;
    cnt_d = cnt_q;
    case ({cnt_inc, cnt_dec})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;
endmodule

// File: rtl/reg_file_sb.sv
// 32x32 register file with write-back bypass on both read ports and a pending-write scoreboard.
// Reads are combinational; write-back lands one edge later; issues are dropped while stall is high.
module reg_file_sb #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              stall,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(rf_pkg::ZERO_REG);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wb_vld;

  assign wb_vld = wb_en && (wb_addr != ZR);

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_vld) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  assign rs_data = (wb_vld && (wb_addr == rs_addr)) ? wb_data : regs_q[rs_addr];
  assign rt_data = (wb_vld && (wb_addr == rt_addr)) ? wb_data : regs_q[rt_addr];

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_busy  (rs_busy),
    .rt_busy  (rt_busy),
    .stall    (stall),
    .busy_cnt (busy_cnt)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset, bypass, r0 handling, stall, same-edge issue/write-back, reset override.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, iss_addr, wb_addr;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        iss_en, wb_en;
  logic        rs_busy, rt_busy, stall;
  logic [5:0]  busy_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rs_busy  (rs_busy),
    .rt_busy  (rt_busy),
    .stall    (stall),
    .busy_cnt (busy_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; iss_en = 1'b0; wb_en = 1'b0;
    rs_addr = '0; rt_addr = '0; iss_addr = '0; wb_addr = '0; wb_data = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    settle();
    check("rst_cnt", 32'(busy_cnt), 32'd0);
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      check($sformatf("rst_rs%0d", i), rs_data, 32'd0);
      check($sformatf("rst_rt%0d", i), rt_data, 32'd0);
      check($sformatf("rst_stall%0d", i), {29'd0, rs_busy, rt_busy, stall}, 32'd0);
    end

    // Same-cycle bypass, then registered read on port B.
    next_cycle();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; rs_addr = 5'd5; rt_addr = 5'd0;
    settle();
    check("byp_rs5", rs_data, 32'hDEADBEEF);
    check("byp_rt0", rt_data, 32'd0);
    next_cycle();
    wb_en = 1'b0; rs_addr = 5'd0; rt_addr = 5'd5;
    settle();
    check("reg_rt5", rt_data, 32'hDEADBEEF);
    check("reg_rs0", rs_data, 32'd0);

    // Register 0 ignores writes and issues.
    next_cycle();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234; rs_addr = 5'd0;
    settle();
    check("r0_nobyp", rs_data, 32'd0);
    next_cycle();
    wb_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd0;
    settle();
    check("r0_after_wr", rs_data, 32'd0);
    next_cycle();
    iss_en = 1'b0;
    settle();
    check("r0_iss_cnt", 32'(busy_cnt), 32'd0);
    check("r0_iss_busy", {31'd0, rs_busy}, 32'd0);

    // Issue r7, read it as source; later issues must be dropped while stalled.
    next_cycle();
    iss_en = 1'b1; iss_addr = 5'd7;
    next_cycle();
    iss_en = 1'b0; rs_addr = 5'd7; rt_addr = 5'd0;
    settle();
    check("r7_rs_busy", {31'd0, rs_busy}, 32'd1);
    check("r7_stall", {31'd0, stall}, 32'd1);
    check("r7_cnt", 32'(busy_cnt), 32'd1);
    next_cycle();
    iss_en = 1'b1; iss_addr = 5'd9;
    next_cycle();
    iss_en = 1'b0; rt_addr = 5'd9;
    settle();
    check("r9_dropped_cnt", 32'(busy_cnt), 32'd1);
    check("r9_dropped_busy", {31'd0, rt_busy}, 32'd0);
    next_cycle();
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
    settle();
    check("r7_wb_rs_busy", {31'd0, rs_busy}, 32'd0);
    check("r7_wb_stall", {31'd0, stall}, 32'd0);
    check("r7_wb_byp", rs_data, 32'h55);
    check("r7_wb_cnt_old", 32'(busy_cnt), 32'd1);
    next_cycle();
    wb_en = 1'b0;
    settle();
    check("r7_cnt_clr", 32'(busy_cnt), 32'd0);
    check("r7_data", rs_data, 32'h55);

    // Same-edge issue and write-back to an already-busy r3.
    next_cycle();
    iss_en = 1'b1; iss_addr = 5'd3;
    next_cycle();
    settle();
    check("r3_cnt1", 32'(busy_cnt), 32'd1);
    next_cycle();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5;
    next_cycle();
    iss_en = 1'b0; wb_en = 1'b0; rs_addr = 5'd3;
    settle();
    check("r3_data", rs_data, 32'hA5);
    check("r3_busy", {31'd0, rs_busy}, 32'd1);
    check("r3_cnt", 32'(busy_cnt), 32'd1);
    next_cycle();
    rs_addr = 5'd0; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h1111;
    next_cycle();
    wb_addr = 5'd12; wb_data = 32'h12;
    next_cycle();
    wb_en = 1'b0; rt_addr = 5'd12;
    settle();
    check("wb_idle_cnt", 32'(busy_cnt), 32'd0);
    check("wb_idle_busy", {31'd0, rt_busy}, 32'd0);
    check("wb_idle_data", rt_data, 32'h12);

    // Fill the scoreboard, then reset with issue and write-back pending.
    next_cycle();
    rs_addr = 5'd0; rt_addr = 5'd0;
    for (int i = 1; i < 32; i++) begin
      iss_en = 1'b1; iss_addr = 5'(i);
      if (i == 16) begin
        settle();
        check("fill_cnt15", 32'(busy_cnt), 32'd15);
      end
      next_cycle();
    end
    iss_en = 1'b0;
    settle();
    check("fill_cnt31", 32'(busy_cnt), 32'd31);
    next_cycle();
    rst = 1'b1; iss_en = 1'b1; iss_addr = 5'd4;
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'hFF;
    next_cycle();
    rst = 1'b0; iss_en = 1'b0; wb_en = 1'b0;
    settle();
    check("rst2_cnt", 32'(busy_cnt), 32'd0);
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(i);
      #1;
      check($sformatf("rst2_busy%0d", i), {30'd0, rs_busy, rt_busy}, 32'd0);
      check($sformatf("rst2_data%0d", i), rs_data, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
